// File: rtl/mem_principal_resp.sv
// Main-memory model (32 x 5 bits) answering cache block fetches and write-backs LATENCIA cycles after acceptance.
// Optional read/write event counters are compiled in with MEM_CONTADORES_EN.
module mem_principal_resp #(
    parameter int LATENCIA = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       solicitacao_de_leitura_na_memoria,
    input  logic       solicitacao_de_escrita_na_memoria,
    input  logic [4:0] endereco,
    input  logic [4:0] dado_escrita,
    output logic [4:0] dado_lido,
    output logic       pronto,
    output logic       ocupado,
`ifdef MEM_CONTADORES_EN
    output logic [7:0] num_leituras,
    output logic [7:0] num_escritas,
`endif
    output logic [1:0] estado
);

    // Handshake: a request is level-held and taken at the first edge seen in OCIOSO;
    // the requester must drop it in the single pronto cycle or it is taken again.
    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ACESSO   = 2'd1,
        RESPOSTA = 2'd2
    } estado_t;

    estado_t    estado_q, estado_d;
    logic [3:0] contador;
    logic [4:0] end_q;
    logic [4:0] dado_q;
    logic       escrita_q;
    logic       aceitar;
    logic       acessar;
    logic [4:0] mem [0:31];

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= OCIOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        aceitar  = 1'b0;
        acessar  = 1'b0;
        pronto   = 1'b0;
        ocupado  = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (solicitacao_de_leitura_na_memoria || solicitacao_de_escrita_na_memoria) begin
                    aceitar  = 1'b1;
                    estado_d = ACESSO;
                end
            end
            ACESSO: begin
                ocupado = 1'b1;
                if (contador == 4'd0) begin
                    acessar  = 1'b1;
                    estado_d = RESPOSTA;
                end
            end
            RESPOSTA: begin
                ocupado  = 1'b1;
                pronto   = 1'b1;
                estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    assign estado = estado_q;

    // A simultaneous read+write is latched as a write; the read is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            contador  <= 4'd0;
            end_q     <= 5'd0;
            dado_q    <= 5'd0;
            escrita_q <= 1'b0;
        end else if (aceitar) begin
            contador  <= 4'(LATENCIA - 1);
            end_q     <= endereco;
            dado_q    <= dado_escrita;
            escrita_q <= solicitacao_de_escrita_na_memoria;
        end else if (estado_q == ACESSO && contador != 4'd0) begin
            contador  <= contador - 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int a = 0; a < 32; a++) begin
                mem[a] <= 5'(a);
            end
        end else if (acessar && escrita_q) begin
            mem[end_q] <= dado_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dado_lido <= 5'd0;
        end else if (acessar && !escrita_q) begin
            dado_lido <= mem[end_q];
        end
    end

`ifdef MEM_CONTADORES_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            num_leituras <= 8'd0;
            num_escritas <= 8'd0;
        end else if (acessar) begin
            if (escrita_q && num_escritas != 8'd255) begin
                num_escritas <= num_escritas + 8'd1;
            end
            if (!escrita_q && num_leituras != 8'd255) begin
                num_leituras <= num_leituras + 8'd1;
            end
        end
    end
`endif

endmodule
